// File: rtl/instruction_set_op_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_set_op_pkg
// Description : Shared widths, A-mux select encodings and add/sub helper for
//               the accumulator datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_set_op_pkg;

    localparam int c_DATA_W = 8;
    localparam int c_ADDR_W = 5;

    typedef enum logic [1:0] {
        ASEL_ADDSUB = 2'b00,
        ASEL_INPUT  = 2'b01,
        ASEL_MEM    = 2'b10,
        ASEL_ZERO   = 2'b11
    } asel_e;

    // Two's-complement A +/- M, wrapping modulo 2**c_DATA_W.
    function automatic logic [c_DATA_W-1:0] f_addsub(
        input logic [c_DATA_W-1:0] a,
        input logic [c_DATA_W-1:0] m,
        input logic                sub
    );
        logic [c_DATA_W-1:0] operand;
        logic [c_DATA_W-1:0] carry_in;
        operand  = sub ? ~m : m;
        carry_in = {{(c_DATA_W-1){1'b0}}, sub};
        return a + operand + carry_in;
    endfunction

endpackage : instruction_set_op_pkg
`default_nettype wire

// File: rtl/instruction_set_op_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_set_op_if
// Description : Control/status bus between the control FSM (master) and the
//               accumulator datapath (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_set_op_if
    import instruction_set_op_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W
);

    logic [DATA_W-1:0] outputOfRAM;
    logic [DATA_W-1:0] input_data;
    logic [DATA_W-1:0] output_data;
    logic [1:0]        Asel;
    logic              Aload;
    logic              Sub;
    logic              Aeq0;
    logic              Apos;
    logic              MemWr;
    logic [ADDR_W-1:0] RAMAddress;

    modport master (
        output input_data,
        output Asel,
        output Aload,
        output Sub,
        output MemWr,
        output RAMAddress,
        input  outputOfRAM,
        input  output_data,
        input  Aeq0,
        input  Apos
    );

    modport slave (
        input  input_data,
        input  Asel,
        input  Aload,
        input  Sub,
        input  MemWr,
        input  RAMAddress,
        output outputOfRAM,
        output output_data,
        output Aeq0,
        output Apos
    );

endinterface : instruction_set_op_if
`default_nettype wire

// File: rtl/instruction_set_op_ram.sv
`default_nettype none
// ============================================================================
// Module      : instruction_set_op_ram
// Description : 2**ADDR_W x DATA_W RAM, synchronous write, asynchronous read.
//               Optional macro RAM_CLEAR_ON_RESET_EN clears all words on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_set_op_ram
    import instruction_set_op_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W
) (
    input  wire logic              Clock,
    input  wire logic              Reset,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [DATA_W-1:0] i_wdata,
    output logic      [DATA_W-1:0] o_rdata
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [c_DEPTH];

`ifdef RAM_CLEAR_ON_RESET_EN
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end
`else
    // No reset on storage; a write attempted while Reset is low is dropped.
    always_ff @(posedge Clock) begin
        if (Reset && i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end
`endif

    assign o_rdata = r_mem[i_addr];

endmodule : instruction_set_op_ram
`default_nettype wire

// File: rtl/instruction_set_op.sv
`default_nettype none
// ============================================================================
// Module      : instruction_set_op
// Description : Accumulator datapath: A register, 4:1 load mux, add/sub unit,
//               status flags and RAM. Honours macro RAM_CLEAR_ON_RESET_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_set_op
    import instruction_set_op_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W
) (
    input wire logic             Clock,
    input wire logic             Reset,
    instruction_set_op_if.slave  bus
);

    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] w_ram_rdata;
    logic [DATA_W-1:0] w_addsub;
    logic [DATA_W-1:0] w_a_next;

    instruction_set_op_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .Clock   (Clock),
        .Reset   (Reset),
        .i_we    (bus.MemWr),
        .i_addr  (bus.RAMAddress),
        .i_wdata (r_a),
        .o_rdata (w_ram_rdata)
    );

    assign w_addsub = f_addsub(r_a, w_ram_rdata, bus.Sub);

    always_comb begin
        w_a_next = '0;
        case (asel_e'(bus.Asel))
            ASEL_ADDSUB: w_a_next = w_addsub;
            ASEL_INPUT:  w_a_next = bus.input_data;
            ASEL_MEM:    w_a_next = w_ram_rdata;
            ASEL_ZERO:   w_a_next = '0;
            default:     w_a_next = '0;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_a <= '0;
        end else if (bus.Aload) begin
            r_a <= w_a_next;
        end
    end

    assign bus.outputOfRAM = w_ram_rdata;
    assign bus.output_data = r_a;
    assign bus.Aeq0        = (r_a == '0);
    assign bus.Apos        = ~r_a[DATA_W-1];

endmodule : instruction_set_op
`default_nettype wire

// File: tb/tb_instruction_set_op.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_set_op
// Description : Directed self-checking bench for the accumulator datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_set_op;
    import instruction_set_op_pkg::*;

    logic Clock;
    logic Reset;
    int   total;
    int   bad;

    instruction_set_op_if bus ();

    instruction_set_op u_dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic [7:0] a, input logic z, input logic p);
        check({tag, "_A"},    bus.output_data, a);
        check({tag, "_Aeq0"}, {7'd0, bus.Aeq0}, {7'd0, z});
        check({tag, "_Apos"}, {7'd0, bus.Apos}, {7'd0, p});
    endtask

    task automatic load_in(input logic [7:0] v);
        bus.Asel = ASEL_INPUT; bus.input_data = v; bus.Aload = 1'b1; bus.MemWr = 1'b0;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Reset = 1'b0;
        bus.input_data = 8'h00; bus.Asel = 2'b00; bus.Aload = 1'b0;
        bus.Sub = 1'b0; bus.MemWr = 1'b0; bus.RAMAddress = 5'd0;
        tick(); tick();
        check_a("reset", 8'h00, 1'b1, 1'b1);
        Reset = 1'b1;
        bus.input_data = 8'h33; bus.Asel = ASEL_INPUT;
        tick();
        check_a("hold_after_reset", 8'h00, 1'b1, 1'b1);

        load_in(8'd10);
        check_a("load_10", 8'd10, 1'b0, 1'b1);

        bus.Aload = 1'b0; bus.MemWr = 1'b1; bus.RAMAddress = 5'd3;
        tick();
        bus.MemWr = 1'b0;
        check("store_ram3", bus.outputOfRAM, 8'd10);

        load_in(8'd25);
        bus.Asel = ASEL_ADDSUB; bus.Sub = 1'b0; tick();
        check_a("add_35", 8'd35, 1'b0, 1'b1);
        bus.Sub = 1'b1; tick();
        check_a("sub_25", 8'd25, 1'b0, 1'b1);

        load_in(8'd5);
        bus.Asel = ASEL_ADDSUB; bus.Sub = 1'b1; tick();
        check_a("sub_neg", 8'hFB, 1'b0, 1'b0);

        load_in(8'd250);
        bus.Asel = ASEL_ADDSUB; bus.Sub = 1'b0; tick();
        check_a("add_wrap", 8'd4, 1'b0, 1'b1);

        bus.Asel = ASEL_MEM; tick();
        check_a("load_mem", 8'd10, 1'b0, 1'b1);
        bus.Asel = ASEL_ZERO; tick();
        check_a("clear", 8'd0, 1'b1, 1'b1);

        // Sub must be ignored on the input path
        bus.Sub = 1'b1; load_in(8'd7);
        check_a("sub_ignored", 8'd7, 1'b0, 1'b1);
        bus.Sub = 1'b0;

        bus.Aload = 1'b0; bus.input_data = 8'd99; tick();
        check_a("hold", 8'd7, 1'b0, 1'b1);

        // Same edge: RAM[3] takes old A (7), A takes pre-edge RAM[3] (10)
        bus.Asel = ASEL_MEM; bus.Aload = 1'b1; bus.MemWr = 1'b1; bus.RAMAddress = 5'd3;
        tick();
        bus.MemWr = 1'b0;
        check_a("wr_ld_same_A", 8'd10, 1'b0, 1'b1);
        check("wr_ld_same_ram", bus.outputOfRAM, 8'd7);

        bus.RAMAddress = 5'd4; bus.MemWr = 1'b1; bus.Aload = 1'b0; tick();
        bus.MemWr = 1'b0;
        check("store_ram4", bus.outputOfRAM, 8'd10);
        bus.RAMAddress = 5'd3;
        check("ram3_kept", bus.outputOfRAM, 8'd7);

        load_in(8'h55);
        check_a("load_55", 8'h55, 1'b0, 1'b1);
        bus.Aload = 1'b0;
        #3 Reset = 1'b0;
        #1;
        check_a("async_reset", 8'h00, 1'b1, 1'b1);

        // Write and load attempted during reset must have no effect
        bus.Asel = ASEL_INPUT; bus.input_data = 8'h66; bus.Aload = 1'b1;
        bus.MemWr = 1'b1; bus.RAMAddress = 5'd3;
        tick();
        check_a("reset_over_load", 8'h00, 1'b1, 1'b1);
        bus.MemWr = 1'b0; bus.Aload = 1'b0;
`ifdef RAM_CLEAR_ON_RESET_EN
        check("ram_cleared", bus.outputOfRAM, 8'h00);
`else
        check("ram_persist", bus.outputOfRAM, 8'd7);
`endif
        Reset = 1'b1;
        tick();
        bus.RAMAddress = 5'd4;
        #1;
`ifdef RAM_CLEAR_ON_RESET_EN
        check("ram4_after_reset", bus.outputOfRAM, 8'h00);
`else
        check("ram4_after_reset", bus.outputOfRAM, 8'd10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_instruction_set_op
`default_nettype wire
